// File: rtl/i_cache_dm.sv
// i_cache_dm: direct-mapped instruction cache with one-word lines.
//
// Sits between the IF stage and the memory controller. A hit returns the
// instruction combinationally in the request cycle. A miss issues one read to
// Mem_ctrl and holds it until the data arrives. The returning word is
// forwarded to IF in its arrival cycle if IF is still asking for that address.
//
// Ports
//   clk, rst                    clock (rising edge), async active-low reset
//   instruction_read_flag/_addr fetch request from IF (held until served)
//   _instruction_flag/_instr    response to IF (hit or forward)
//   flush                       one-cycle pulse, invalidates every line
//   _instruction_read_flag/_addr read request to Mem_ctrl
//   instruction_flag/instruction read data from Mem_ctrl (one-cycle valid)
//   hit_count, miss_count       saturating performance counters
module i_cache_dm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instruction_read_flag,
    input  logic [ADDR_W-1:0] instruction_read_address,
    output logic              _instruction_flag,
    output logic [DATA_W-1:0] _instruction,
    input  logic              flush,
    output logic              _instruction_read_flag,
    output logic [ADDR_W-1:0] _instruction_read_address,
    input  logic              instruction_flag,
    input  logic [DATA_W-1:0] instruction,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE, MISS} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic               flush_pend_q, flush_pend_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    // Tag and data arrays are never reset; valid_q alone decides residency.
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  data_mem [LINES];

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               hit, fwd, fill_we;

    assign req_idx  = instruction_read_address[INDEX_W+1:2];
    assign req_tag  = instruction_read_address[ADDR_W-1:INDEX_W+2];
    assign fill_idx = miss_addr_q[INDEX_W+1:2];
    assign fill_tag = miss_addr_q[ADDR_W-1:INDEX_W+2];

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        hit          = 1'b0;
        fwd          = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (instruction_read_flag) begin
                    // A flush in the lookup cycle forces a miss so stale code
                    // is never returned after fence.i.
                    if (valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush) begin
                        hit = 1'b1;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        miss_addr_d = instruction_read_address;
                        state_d     = MISS;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            MISS: begin
                if (instruction_flag) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                    // A fill that straddles a flush may predate the code
                    // update, so it is forwarded but not kept.
                    fill_we      = !flush && !flush_pend_q;
                    fwd          = instruction_read_flag &&
                                   (instruction_read_address[ADDR_W-1:2] == miss_addr_q[ADDR_W-1:2]);
                    if (fill_we) valid_d[fill_idx] = 1'b1;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= instruction;
        end
    end

    assign _instruction_flag         = rst && (hit || fwd);
    assign _instruction              = !rst ? '0 :
                                       hit  ? data_mem[req_idx] :
                                       fwd  ? instruction : '0;
    assign _instruction_read_flag    = (state_q == MISS);
    assign _instruction_read_address = miss_addr_q;
    assign hit_count                 = hit_cnt_q;
    assign miss_count                = miss_cnt_q;
endmodule

// File: tb/tb_i_cache_dm.sv
// Directed bench for i_cache_dm (INDEX_W=8, CNT_W=4).
module tb_i_cache_dm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifreq = 1'b0;
    logic [31:0] ifaddr = '0;
    logic        ifflag;
    logic [31:0] ifdata;
    logic        flush = 1'b0;
    logic        mrd;
    logic [31:0] maddr;
    logic        mflag = 1'b0;
    logic [31:0] mdata = '0;
    logic [3:0]  hits, misses;

    int n_cmp = 0;
    int n_bad = 0;

    i_cache_dm #(.ADDR_W(32), .DATA_W(32), .INDEX_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .instruction_read_flag(ifreq), .instruction_read_address(ifaddr),
        ._instruction_flag(ifflag), ._instruction(ifdata),
        .flush(flush),
        ._instruction_read_flag(mrd), ._instruction_read_address(maddr),
        .instruction_flag(mflag), .instruction(mdata),
        .hit_count(hits), .miss_count(misses)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0; ifreq = 1'b0; mflag = 1'b0; flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Drives a fetch that misses; memory answers after lat wait cycles.
    // flush_at: cycle offset (0 = request cycle) at which flush pulses, -1 none.
    task automatic miss_fill(input logic [31:0] a, input logic [31:0] w, input int lat,
                             input int flush_at, output int rdcnt, output logic fwd,
                             output logic [31:0] fdata);
        rdcnt = 0; fwd = 1'b0; fdata = '0;
        ifreq = 1'b1; ifaddr = a; flush = (flush_at == 0);
        @(negedge clk); if (mrd) rdcnt++;
        for (int i = 1; i <= lat + 1; i++) begin
            @(posedge clk); #1;
            flush = (flush_at == i);
            if (i == lat + 1) begin mflag = 1'b1; mdata = w; end
            @(negedge clk); if (mrd) rdcnt++;
            if (i == lat + 1) begin fwd = ifflag; fdata = ifdata; end
        end
        @(posedge clk); #1;
        mflag = 1'b0; flush = 1'b0; ifreq = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, output logic f, output logic [31:0] d,
                          output logic r);
        ifreq = 1'b1; ifaddr = a;
        @(negedge clk); f = ifflag; d = ifdata; r = mrd;
        @(posedge clk); #1; ifreq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ifreq = 1'b1; ifaddr = 32'h100; mflag = 1'b1; mdata = 32'h1234;
        @(negedge clk);
        n_cmp++; if (ifflag !== 1'b0) begin n_bad++; $display("FAIL rst_ifflag got %0h want 0", ifflag); end
        n_cmp++; if (ifdata !== 32'h0) begin n_bad++; $display("FAIL rst_ifdata got %0h want 0", ifdata); end
        n_cmp++; if (mrd !== 1'b0) begin n_bad++; $display("FAIL rst_mrd got %0h want 0", mrd); end
        n_cmp++; if (maddr !== 32'h0) begin n_bad++; $display("FAIL rst_maddr got %0h want 0", maddr); end
        n_cmp++; if (hits !== 4'd0 || misses !== 4'd0) begin n_bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", hits, misses); end
        do_reset();
    endtask

    task automatic test_cold_miss();
        int rc; logic f, r; logic [31:0] d;
        do_reset();
        miss_fill(32'h100, 32'h00500093, 3, -1, rc, f, d);
        n_cmp++; if (rc !== 4) begin n_bad++; $display("FAIL cold_rd_cycles got %0d want 4", rc); end
        n_cmp++; if (f !== 1'b1 || d !== 32'h00500093) begin n_bad++; $display("FAIL cold_forward got %0h/%0h want 1/00500093", f, d); end
        lookup(32'h100, f, d, r);
        n_cmp++; if (f !== 1'b1 || d !== 32'h00500093) begin n_bad++; $display("FAIL cold_refetch_hit got %0h/%0h want 1/00500093", f, d); end
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL cold_rd_after got %0h want 0", r); end
        n_cmp++; if (hits !== 4'd1 || misses !== 4'd1) begin n_bad++; $display("FAIL cold_counts got %0d/%0d want 1/1", hits, misses); end
    endtask

    task automatic test_conflict();
        int rc; logic f, r; logic [31:0] d;
        do_reset();
        miss_fill(32'h100, 32'hAAAA0001, 1, -1, rc, f, d);
        miss_fill(32'h500, 32'hBBBB0002, 1, -1, rc, f, d);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL conf_500_miss got %0d want 2", rc); end
        lookup(32'h500, f, d, r);
        n_cmp++; if (f !== 1'b1 || d !== 32'hBBBB0002) begin n_bad++; $display("FAIL conf_500_hit got %0h/%0h want 1/bbbb0002", f, d); end
        miss_fill(32'h100, 32'hCCCC0003, 1, -1, rc, f, d);
        n_cmp++; if (rc !== 2 || d !== 32'hCCCC0003) begin n_bad++; $display("FAIL conf_100_remiss got %0d/%0h want 2/cccc0003", rc, d); end
        n_cmp++; if (misses !== 4'd3 || hits !== 4'd1) begin n_bad++; $display("FAIL conf_counts got %0d/%0d want 3/1", misses, hits); end
    endtask

    task automatic test_flush();
        int rc; logic f, r; logic [31:0] d;
        do_reset();
        miss_fill(32'h100, 32'h11111111, 1, -1, rc, f, d);
        miss_fill(32'h104, 32'h22222222, 1, -1, rc, f, d);
        lookup(32'h104, f, d, r);
        n_cmp++; if (f !== 1'b1 || d !== 32'h22222222) begin n_bad++; $display("FAIL fl_pre_hit got %0h/%0h want 1/22222222", f, d); end
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        miss_fill(32'h100, 32'h33333333, 1, -1, rc, f, d);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL fl_idle_miss got %0d want 2", rc); end
        // Flush during the 0x200 miss: forwarded but not kept.
        miss_fill(32'h200, 32'h44444444, 2, 1, rc, f, d);
        n_cmp++; if (f !== 1'b1 || d !== 32'h44444444) begin n_bad++; $display("FAIL fl_mid_fwd got %0h/%0h want 1/44444444", f, d); end
        miss_fill(32'h200, 32'h55555555, 1, -1, rc, f, d);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL fl_mid_not_resident got %0d want 2", rc); end
        // 0x200 is now resident; a flush in the lookup cycle still forces a miss.
        miss_fill(32'h200, 32'h66666666, 1, 0, rc, f, d);
        n_cmp++; if (rc !== 2 || d !== 32'h66666666) begin n_bad++; $display("FAIL fl_same_cycle got %0d/%0h want 2/66666666", rc, d); end
        n_cmp++; if (misses !== 4'd6 || hits !== 4'd1) begin n_bad++; $display("FAIL fl_counts got %0d/%0d want 6/1", misses, hits); end
    endtask

    task automatic test_redirect();
        logic f, r; logic [31:0] d;
        do_reset();
        ifreq = 1'b1; ifaddr = 32'h300;
        @(posedge clk); #1;
        ifaddr = 32'h400;
        @(posedge clk); #1;
        mflag = 1'b1; mdata = 32'h30303030;
        @(negedge clk);
        n_cmp++; if (ifflag !== 1'b0) begin n_bad++; $display("FAIL redir_no_fwd got %0h want 0", ifflag); end
        @(posedge clk); #1; mflag = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifflag !== 1'b0 || mrd !== 1'b0) begin n_bad++; $display("FAIL redir_400_lookup got %0h/%0h want 0/0", ifflag, mrd); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (mrd !== 1'b1 || maddr !== 32'h400) begin n_bad++; $display("FAIL redir_400_req got %0h/%0h want 1/400", mrd, maddr); end
        @(posedge clk); #1; mflag = 1'b1; mdata = 32'h40404040;
        @(negedge clk);
        n_cmp++; if (ifflag !== 1'b1 || ifdata !== 32'h40404040) begin n_bad++; $display("FAIL redir_400_fwd got %0h/%0h want 1/40404040", ifflag, ifdata); end
        @(posedge clk); #1; mflag = 1'b0; ifreq = 1'b0;
        lookup(32'h300, f, d, r);
        n_cmp++; if (f !== 1'b1 || d !== 32'h30303030) begin n_bad++; $display("FAIL redir_300_resident got %0h/%0h want 1/30303030", f, d); end
        n_cmp++; if (misses !== 4'd2 || hits !== 4'd1) begin n_bad++; $display("FAIL redir_counts got %0d/%0d want 2/1", misses, hits); end
    endtask

    task automatic test_reset_mid_miss();
        int rc; logic f; logic [31:0] d;
        do_reset();
        ifreq = 1'b1; ifaddr = 32'h600;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (mrd !== 1'b1) begin n_bad++; $display("FAIL rmm_in_miss got %0h want 1", mrd); end
        #1; rst = 1'b0; ifreq = 1'b0;
        #2;
        n_cmp++; if (mrd !== 1'b0) begin n_bad++; $display("FAIL rmm_async_rd got %0h want 0", mrd); end
        @(posedge clk); #1; rst = 1'b1;
        mflag = 1'b1; mdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (ifflag !== 1'b0 || mrd !== 1'b0) begin n_bad++; $display("FAIL rmm_late_flag got %0h/%0h want 0/0", ifflag, mrd); end
        @(posedge clk); #1; mflag = 1'b0;
        miss_fill(32'h600, 32'h60606060, 1, -1, rc, f, d);
        n_cmp++; if (rc !== 2 || d !== 32'h60606060) begin n_bad++; $display("FAIL rmm_no_write got %0d/%0h want 2/60606060", rc, d); end
    endtask

    task automatic test_saturation();
        int rc, nh; logic f; logic [31:0] d;
        do_reset();
        miss_fill(32'h100, 32'h0000ABCD, 1, -1, rc, f, d);
        nh = 0;
        ifreq = 1'b1; ifaddr = 32'h100;
        repeat (20) begin
            @(negedge clk); if (ifflag === 1'b1 && ifdata === 32'h0000ABCD) nh++;
            @(posedge clk); #1;
        end
        ifreq = 1'b0;
        n_cmp++; if (nh !== 20) begin n_bad++; $display("FAIL sat_hits_served got %0d want 20", nh); end
        n_cmp++; if (hits !== 4'd15) begin n_bad++; $display("FAIL sat_hit_count got %0d want 15", hits); end
        n_cmp++; if (misses !== 4'd1) begin n_bad++; $display("FAIL sat_miss_count got %0d want 1", misses); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush();
        test_redirect();
        test_reset_mid_miss();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
